// File: rtl/riscv_decode_buffer.sv
// riscv_decode_buffer
//   Registered, buffered RV32I instruction decoder. Each accepted instruction/PC
//   pair is decoded (format, raw fields, immediate, illegal flag) and the record
//   is queued in a DEPTH-entry FIFO that is drained over a second handshake.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   flush_i                 synchronous flush, empties the FIFO (beats push/pop)
//   in_valid_i/in_ready_o   input handshake; in_ready_o = FIFO not full
//   instr_i, pc_i           instruction word and its address
//   out_valid_o/out_ready_i output handshake; out_valid_o = FIFO not empty
//   format_o                R=0 I=1 S=2 B=3 U=4 J=5 ERR=6
//   op_o, funct_3_o, funct_7_o, rd_o, rs1_o, rs2_o   raw instruction fields
//   imm_o, pc_o, illegal_o  decoded immediate, pc, illegal flag of head record
//   count_o                 occupied entries
module riscv_decode_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          SIGN_EXT = 1'b1,
  parameter bit          EN_M     = 1'b0,
  parameter int unsigned PC_W     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              instr_i,
  input  logic [PC_W-1:0]          pc_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [2:0]               format_o,
  output logic [6:0]               op_o,
  output logic [2:0]               funct_3_o,
  output logic [6:0]               funct_7_o,
  output logic [4:0]               rd_o,
  output logic [4:0]               rs1_o,
  output logic [4:0]               rs2_o,
  output logic [31:0]              imm_o,
  output logic [PC_W-1:0]          pc_o,
  output logic                     illegal_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ERR = 3'd6;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [31:0]     imm;
    logic            illegal;
    logic [31:0]     instr;
    logic [PC_W-1:0] pc;
  } rec_t;

  // ---------------- decode ----------------
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       s;
  logic [2:0] fmt_d;
  logic [31:0] imm_d;
  logic       illegal_d;
  logic       r_ok;
  logic       sys_ok;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign s      = SIGN_EXT ? instr_i[31] : 1'b0;

  always_comb begin
    fmt_d = FMT_ERR;
    case (opcode)
      7'b0110011:                                   fmt_d = FMT_R;
      7'b0010011, 7'b1100111, 7'b0000011, 7'b1110011: fmt_d = FMT_I;
      7'b0100011:                                   fmt_d = FMT_S;
      7'b1100011:                                   fmt_d = FMT_B;
      7'b0110111, 7'b0010111:                       fmt_d = FMT_U;
      7'b1101111:                                   fmt_d = FMT_J;
      default:                                      fmt_d = FMT_ERR;
    endcase
  end

  always_comb begin
    imm_d = 32'd0;
    case (fmt_d)
      FMT_I: imm_d = {{20{s}}, instr_i[31:20]};
      FMT_S: imm_d = {{20{s}}, instr_i[31:25], instr_i[11:7]};
      FMT_B: imm_d = {{19{s}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U: imm_d = {instr_i[31:12], 12'b0};
      FMT_J: imm_d = {{11{s}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      default: imm_d = 32'd0;
    endcase
  end

  // f7=0x20 is only meaningful for SUB (f3=0) and SRA (f3=5).
  assign r_ok = (f7 == 7'h00) ||
                ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))) ||
                (EN_M && (f7 == 7'h01));
  // f3=0 must be exactly ECALL/EBREAK; f3=4 is unused in the SYSTEM space.
  assign sys_ok = (instr_i == 32'h0000_0073) || (instr_i == 32'h0010_0073) ||
                  ((f3 != 3'd0) && (f3 != 3'd4));

  always_comb begin
    illegal_d = (fmt_d == FMT_ERR) || (instr_i[1:0] != 2'b11);
    case (opcode)
      7'b1100111: if (f3 != 3'd0) illegal_d = 1'b1;
      7'b1100011: if ((f3 == 3'd2) || (f3 == 3'd3)) illegal_d = 1'b1;
      7'b0000011: if ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7)) illegal_d = 1'b1;
      7'b0100011: if (f3 > 3'd2) illegal_d = 1'b1;
      7'b0010011: begin
        if ((f3 == 3'd1) && (f7 != 7'h00)) illegal_d = 1'b1;
        if ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20)) illegal_d = 1'b1;
      end
      7'b0110011: if (!r_ok) illegal_d = 1'b1;
      7'b1110011: if (!sys_ok) illegal_d = 1'b1;
      default: ;
    endcase
  end

  rec_t rec_d;
  assign rec_d = '{fmt: fmt_d, imm: imm_d, illegal: illegal_d, instr: instr_i, pc: pc_i};

  // ---------------- FIFO ----------------
  rec_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  rec_t             head;

  assign in_ready_o  = (count_q != CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  // Flush wins: neither side of the handshake takes effect in a flush cycle.
  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= rec_d;
  end

  assign head = out_valid_o ? mem_q[rd_ptr_q] : '0;

  assign format_o  = head.fmt;
  assign op_o      = head.instr[6:0];
  assign funct_3_o = head.instr[14:12];
  assign funct_7_o = head.instr[31:25];
  assign rd_o      = head.instr[11:7];
  assign rs1_o     = head.instr[19:15];
  assign rs2_o     = head.instr[24:20];
  assign imm_o     = head.imm;
  assign pc_o      = head.pc;
  assign illegal_o = head.illegal;
  assign count_o   = count_q;

endmodule

// File: tb/tb_riscv_decode_buffer.sv
module tb_riscv_decode_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0;
  logic        in_ready, out_valid, illegal;
  logic [2:0]  fmt, f3;
  logic [6:0]  op, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm, pc_o;
  logic [2:0]  count;

  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [31:0] b_instr = '0, b_pc = '0;
  logic        b_in_ready, b_out_valid, b_illegal;
  logic [2:0]  b_fmt, b_f3;
  logic [6:0]  b_op, b_f7;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [31:0] b_imm, b_pc_o;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;

  riscv_decode_buffer #(.DEPTH(4), .SIGN_EXT(1'b1), .EN_M(1'b0), .PC_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .format_o(fmt), .op_o(op), .funct_3_o(f3), .funct_7_o(f7), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2),
    .imm_o(imm), .pc_o(pc_o), .illegal_o(illegal), .count_o(count));

  riscv_decode_buffer #(.DEPTH(4), .SIGN_EXT(1'b0), .EN_M(1'b1), .PC_W(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .instr_i(b_instr), .pc_i(b_pc), .out_valid_o(b_out_valid), .out_ready_i(b_out_ready),
    .format_o(b_fmt), .op_o(b_op), .funct_3_o(b_f3), .funct_7_o(b_f7), .rd_o(b_rd), .rs1_o(b_rs1),
    .rs2_o(b_rs2), .imm_o(b_imm), .pc_o(b_pc_o), .illegal_o(b_illegal), .count_o(b_count));

  typedef struct {
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill;
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];

  // Reference decode for SIGN_EXT=1, EN_M=0; immediates built with arithmetic shifts.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
    exp_t e;
    logic signed [31:0] t;
    logic [2:0] c3;
    logic [6:0] c7;
    c3 = ins[14:12];
    c7 = ins[31:25];
    e.instr = ins; e.pc = p; e.fmt = 3'd6; e.imm = 32'd0;
    case (ins[6:0])
      7'h33: e.fmt = 3'd0;
      7'h13, 7'h67, 7'h03, 7'h73: begin e.fmt = 3'd1; t = ins; e.imm = t >>> 20; end
      7'h23: begin e.fmt = 3'd2; t = {ins[31:25], ins[11:7], 20'h0}; e.imm = t >>> 20; end
      7'h63: begin e.fmt = 3'd3; t = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'h0}; e.imm = t >>> 19; end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin e.fmt = 3'd5; t = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'h0}; e.imm = t >>> 11; end
      default: ;
    endcase
    e.ill = (e.fmt == 3'd6) || (ins[1:0] != 2'b11);
    case (ins[6:0])
      7'h67: if (c3 != 3'd0) e.ill = 1'b1;
      7'h63: if (c3 inside {3'd2, 3'd3}) e.ill = 1'b1;
      7'h03: if (c3 inside {3'd3, 3'd6, 3'd7}) e.ill = 1'b1;
      7'h23: if (c3 > 3'd2) e.ill = 1'b1;
      7'h13: if ((c3 == 3'd1 && c7 != 7'h00) || (c3 == 3'd5 && !(c7 inside {7'h00, 7'h20}))) e.ill = 1'b1;
      7'h33: if (!(c7 == 7'h00 || (c7 == 7'h20 && c3 inside {3'd0, 3'd5}))) e.ill = 1'b1;
      7'h73: if (ins != 32'h73 && ins != 32'h0010_0073 && c3 inside {3'd0, 3'd4}) e.ill = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Scoreboard: expected record queued at each accepted push, compared at each pop.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_pop: got pc=%h instr_op=%h, expected no record", pc_o, op);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (fmt !== e.fmt || op !== e.instr[6:0] || f3 !== e.instr[14:12] || f7 !== e.instr[31:25] ||
              rd !== e.instr[11:7] || rs1 !== e.instr[19:15] || rs2 !== e.instr[24:20] ||
              imm !== e.imm || pc_o !== e.pc || illegal !== e.ill) begin
            errors++;
            $display("FAIL sb_record instr=%h: got fmt=%0d imm=%h ill=%b pc=%h op=%h f3=%0d f7=%h rd=%0d rs1=%0d rs2=%0d, expected fmt=%0d imm=%h ill=%b pc=%h",
                     e.instr, fmt, imm, illegal, pc_o, op, f3, f7, rd, rs1, rs2, e.fmt, e.imm, e.ill, e.pc);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(instr, pc));
    end
  end

  // Reset drops anything accepted in the current cycle as well.
  always @(negedge rst_n) sb.delete();

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    rst_n = 1'b1;
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if ({fmt, imm, pc_o, illegal, rd} !== '0) begin errors++; $display("FAIL reset_data: got fmt=%0d imm=%h pc=%h ill=%b expected all 0", fmt, imm, pc_o, illegal); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; instr = 32'hFFF0_0093; pc = 32'h100; out_ready = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_no_bypass: got out_valid=%b expected 0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || fmt !== 3'd1 || rd !== 5'd1 || imm !== 32'hFFFF_FFFF || pc_o !== 32'h100 || illegal !== 1'b0)
      begin errors++; $display("FAIL addi: got v=%b fmt=%0d rd=%0d imm=%h pc=%h ill=%b expected v=1 fmt=1 rd=1 imm=ffffffff pc=100 ill=0", out_valid, fmt, rd, imm, pc_o, illegal); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL addi_count: got %0d expected 1", count); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL addi_pop_count: got %0d expected 0", count); end
  endtask

  task automatic test_branch();
    in_valid = 1'b1; instr = 32'hFE00_0EE3; pc = 32'h200;
    b_in_valid = 1'b1; b_instr = 32'hFE00_0EE3; b_pc = 32'h200;
    tick();
    in_valid = 1'b0; b_in_valid = 1'b0;
    checks++; if (fmt !== 3'd3 || imm !== 32'hFFFF_FFFC) begin errors++; $display("FAIL beq_sext: got fmt=%0d imm=%h expected fmt=3 imm=fffffffc", fmt, imm); end
    checks++; if (b_fmt !== 3'd3 || b_imm !== 32'h0000_1FFC) begin errors++; $display("FAIL beq_zext: got fmt=%0d imm=%h expected fmt=3 imm=00001ffc", b_fmt, b_imm); end
    out_ready = 1'b1; b_out_ready = 1'b1; tick(); out_ready = 1'b0; b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_instr = 32'hFFF0_0093; tick(); b_in_valid = 1'b0;
    checks++; if (b_imm !== 32'h0000_0FFF || b_fmt !== 3'd1) begin errors++; $display("FAIL addi_zext: got fmt=%0d imm=%h expected fmt=1 imm=00000fff", b_fmt, b_imm); end
    b_out_ready = 1'b1; tick(); b_out_ready = 1'b0;
  endtask

  task automatic test_illegal();
    in_valid = 1'b1; instr = 32'h0; pc = 32'h300; tick(); in_valid = 1'b0;
    checks++; if (fmt !== 3'd6 || illegal !== 1'b1 || imm !== 32'h0) begin errors++; $display("FAIL zero_word: got fmt=%0d ill=%b imm=%h expected fmt=6 ill=1 imm=0", fmt, illegal, imm); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0220_8033; pc = 32'h304;
    b_in_valid = 1'b1; b_instr = 32'h0220_8033; b_pc = 32'h304;
    tick();
    in_valid = 1'b0; b_in_valid = 1'b0;
    checks++; if (illegal !== 1'b1 || fmt !== 3'd0) begin errors++; $display("FAIL mul_no_m: got ill=%b fmt=%0d expected ill=1 fmt=0", illegal, fmt); end
    checks++; if (b_illegal !== 1'b0 || b_fmt !== 3'd0) begin errors++; $display("FAIL mul_en_m: got ill=%b fmt=%0d expected ill=0 fmt=0", b_illegal, b_fmt); end
    out_ready = 1'b1; b_out_ready = 1'b1; tick(); out_ready = 1'b0; b_out_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] w [5];
    for (int k = 0; k < 5; k++) w[k] = {12'(k + 1), 5'd2, 3'd0, 5'd1, 7'h13};
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin instr = w[k]; pc = 32'h400 + 32'(4 * k); tick(); end
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full: got count=%0d in_ready=%b expected count=4 in_ready=0", count, in_ready); end
    instr = w[4]; pc = 32'h410; tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_hold: got count=%0d expected 4", count); end
    out_ready = 1'b1; tick();
    checks++; if (count !== 3'd3 || in_ready !== 1'b1) begin errors++; $display("FAIL full_pop_only: got count=%0d in_ready=%b expected count=3 in_ready=1", count, in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_push_pop: got count=%0d expected 3", count); end
    for (int k = 0; k < 10 && count != 3'd0; k++) tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || sb.size() != 0) begin errors++; $display("FAIL full_drain: got count=%0d pending=%0d expected 0 and 0", count, sb.size()); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin instr = 32'h0000_0013 | (32'(k) << 7); pc = 32'h500 + 32'(4 * k); tick(); end
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre: got count=%0d expected 3", count); end
    flush = 1'b1; instr = 32'h1234_50B7; pc = 32'h5FC; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush: got count=%0d v=%b rdy=%b expected 0 0 1", count, out_valid, in_ready); end
    tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_lost: got count=%0d expected 0", count); end
    in_valid = 1'b1; instr = 32'h0040_006F; pc = 32'h600; tick(); in_valid = 1'b0;
    checks++; if (pc_o !== 32'h600 || fmt !== 3'd5 || imm !== 32'h4) begin errors++; $display("FAIL flush_after: got pc=%h fmt=%0d imm=%h expected pc=600 fmt=5 imm=4", pc_o, fmt, imm); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    instr = 32'h0010_0113; pc = 32'h700; tick();
    instr = 32'h0020_0193; pc = 32'h704; tick();
    instr = 32'h0030_0213; pc = 32'h708;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL async_reset_ctl: got v=%b rdy=%b count=%0d expected 0 1 0", out_valid, in_ready, count); end
    checks++; if ({fmt, imm, pc_o, illegal} !== '0) begin errors++; $display("FAIL async_reset_data: got fmt=%0d imm=%h pc=%h expected 0", fmt, imm, pc_o); end
    in_valid = 1'b0;
    tick();
    #2 rst_n = 1'b1;
    tick();
    in_valid = 1'b1; instr = 32'hABCD_E2B7; pc = 32'h900; tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || pc_o !== 32'h900 || fmt !== 3'd4 || imm !== 32'hABCD_E000) begin errors++; $display("FAIL async_reset_fresh: got v=%b pc=%h fmt=%0d imm=%h expected 1 900 4 abcde000", out_valid, pc_o, fmt, imm); end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      instr = {7'h00, 5'(k), 5'(k + 1), 3'd0, 5'(k + 2), 7'h33}; pc = 32'hA00 + 32'(4 * k);
      tick();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count[%0d]: got %0d expected 1", k, count); end
    end
    in_valid = 1'b0; tick(); out_ready = 1'b0;
    checks++; if (count !== 3'd0 || sb.size() != 0) begin errors++; $display("FAIL b2b_drain: got count=%0d pending=%0d expected 0 and 0", count, sb.size()); end
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic [31:0] r;
    ops = '{7'h33, 7'h13, 7'h67, 7'h03, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      if ($urandom_range(0, 9) != 0) r[6:0] = ops[$urandom_range(0, 9)];
      if (r[6:0] == 7'h33 || r[6:0] == 7'h13) begin
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: r[31:25] = 7'h01;
          default: ;
        endcase
      end
      if (r[6:0] == 7'h73 && $urandom_range(0, 2) == 0) r = $urandom_range(0, 1) != 0 ? 32'h73 : 32'h0010_0073;
      in_valid = $urandom_range(0, 1) != 0; instr = r; pc = $urandom;
      out_ready = $urandom_range(0, 2) != 0;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 10 && count != 3'd0; k++) tick();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0 || sb.size() != 0) begin errors++; $display("FAIL random_drain: got count=%0d pending=%0d expected 0 and 0", count, sb.size()); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_illegal();
    test_full();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_random();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
